// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: symbolic request in, machine word plus byte address out.
// Optional macro INSTR_ENCODER_CHECK_EN enables kind/immediate range checking and the sticky error flag.
module instruction_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_kind,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7b5,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  error,
    output logic [15:0]           count
);

    localparam logic [ADDR_WIDTH-1:0] BASE = BASE_ADDR[ADDR_WIDTH-1:0];

    typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_OUTPUT} state_t;
    state_t state;

    logic [3:0]  k_kind;
    logic [2:0]  k_f3;
    logic        k_f7b5;
    logic [4:0]  k_rd;
    logic [4:0]  k_rs1;
    logic [4:0]  k_rs2;
    logic [31:0] k_imm;

    logic [31:0] enc_word;
    logic        range_ok;
    logic        is_shift;
    logic [6:0]  funct7;

    assign is_shift = (k_f3 == 3'b001) || (k_f3 == 3'b101);
    assign funct7   = {1'b0, k_f7b5, 5'b00000};

    always_comb begin
        enc_word = 32'h0000_0013;
        case (k_kind)
            4'd0: enc_word = {k_imm[11:0], k_rs1, 3'b010, k_rd, 7'h03};
            4'd1: enc_word = {k_imm[11:5], k_rs2, k_rs1, 3'b010, k_imm[4:0], 7'h23};
            4'd2: enc_word = {funct7, k_rs2, k_rs1, k_f3, k_rd, 7'h33};
            4'd3: enc_word = {k_imm[31:12], k_rd, 7'h37};
            4'd4: enc_word = {k_imm[12], k_imm[10:5], k_rs2, k_rs1, 3'b000,
                              k_imm[4:1], k_imm[11], 7'h63};
            4'd5: enc_word = {k_imm[12], k_imm[10:5], k_rs2, k_rs1, 3'b001,
                              k_imm[4:1], k_imm[11], 7'h63};
            4'd6: begin
                if (is_shift)
                    enc_word = {funct7, k_imm[4:0], k_rs1, k_f3, k_rd, 7'h13};
                else
                    enc_word = {k_imm[11:0], k_rs1, k_f3, k_rd, 7'h13};
            end
            4'd7: enc_word = {k_imm[20], k_imm[10:1], k_imm[11], k_imm[19:12], k_rd, 7'h6F};
            default: enc_word = 32'h0000_0013;
        endcase
    end

`ifdef INSTR_ENCODER_CHECK_EN
    logic signed [31:0] imm_s;
    logic in12, in_shamt, in_br, in_jal;

    assign imm_s    = k_imm;
    assign in12     = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign in_shamt = (imm_s >= 32'sd0) && (imm_s <= 32'sd31);
    assign in_br    = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !k_imm[0];
    assign in_jal   = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !k_imm[0];

    always_comb begin
        range_ok = 1'b0;
        case (k_kind)
            4'd0, 4'd1: range_ok = in12;
            4'd2:       range_ok = 1'b1;
            4'd3:       range_ok = (k_imm[11:0] == 12'h000);
            4'd4, 4'd5: range_ok = in_br;
            4'd6:       range_ok = is_shift ? in_shamt : in12;
            4'd7:       range_ok = in_jal;
            default:    range_ok = 1'b0;
        endcase
    end
`else
    // Unchecked build: fields are truncated and illegal kinds become a nop.
    assign range_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_addr  <= BASE;
            error     <= 1'b0;
            count     <= 16'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        k_kind   <= in_kind;
                        k_f3     <= in_funct3;
                        k_f7b5   <= in_funct7b5;
                        k_rd     <= in_rd;
                        k_rs1    <= in_rs1;
                        k_rs2    <= in_rs2;
                        k_imm    <= in_imm;
                        in_ready <= 1'b0;
                        state    <= S_ENCODE;
                    end
                end
                S_ENCODE: begin
                    if (range_ok) begin
                        out_instr <= enc_word;
                        out_valid <= 1'b1;
                        state     <= S_OUTPUT;
                    end else begin
                        error    <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_addr  <= out_addr + ADDR_WIDTH'(4);
                        if (count != 16'hFFFF)
                            count <= count + 16'd1;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: expected {addr, word} pairs queued at request time.
module tb_instruction_encoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_kind = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7b5 = 1'b0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        error;
    logic [15:0] count;

    int total = 0;
    int bad = 0;
    logic [39:0] sb[$];
    logic [7:0]  exp_addr = 8'h00;
    int          exp_count = 0;

    instruction_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .error(error), .count(count)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Scoreboard: a handshake occurs on the next rising edge.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            logic [39:0] e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got instr=%08h addr=%02h, none expected", out_instr, out_addr);
            end else begin
                e = sb.pop_front();
                if (out_instr !== e[31:0] || out_addr !== e[39:32]) begin
                    bad++;
                    $display("FAIL word: got instr=%08h addr=%02h, expected instr=%08h addr=%02h",
                             out_instr, out_addr, e[31:0], e[39:32]);
                end
            end
        end
    end

    task automatic send(input logic [3:0] kind, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic emit, input logic [31:0] exp_instr);
        bit accepted = 0;
        in_kind = kind; in_funct3 = f3; in_funct7b5 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (in_ready === 1'b1) begin
                accepted = 1;
                break;
            end
        end
        if (!accepted) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready never rose for kind=%0d", kind);
            in_valid = 1'b0;
            return;
        end
        if (emit) begin
            sb.push_back({exp_addr, exp_instr});
            exp_addr += 8'd4;
            exp_count++;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock); #2;
            if (sb.size() == 0 && out_valid === 1'b0 && in_ready === 1'b1) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL drain_%s: pending=%0d out_valid=%b in_ready=%b", tag, sb.size(), out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_instr !== 32'h0 ||
            out_addr !== 8'h00 || error !== 1'b0 || count !== 16'h0) begin
            bad++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b instr=%08h addr=%02h error=%b count=%0d, expected 0 0 0 0 0 0",
                     in_ready, out_valid, out_instr, out_addr, error, count);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_addi_latency;
        out_ready = 1'b1;
        send(4'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
        // send returns 1 ns after the accept edge; the word must appear after the next edge.
        @(negedge clock);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: out_valid=%b in encode cycle, expected 0", out_valid);
        end
        @(negedge clock);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL latency: out_valid=%b two cycles after accept, expected 1", out_valid);
        end
        wait_drain("addi");
        total++;
        if (count !== 16'd1) begin
            bad++;
            $display("FAIL count_addi: got %0d expected 1", count);
        end
    endtask

    task automatic test_sequence;
        send(4'd0, 3'b000, 1'b0, 5'd2, 5'd1, 5'd9, 32'd8, 1'b1, 32'h0080A103);
        send(4'd1, 3'b000, 1'b0, 5'd7, 5'd1, 5'd2, 32'd4, 1'b1, 32'h0020A223);
        send(4'd2, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        send(4'd2, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3);
        send(4'd3, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7);
        send(4'd6, 3'b101, 1'b1, 5'd4, 5'd3, 5'd0, 32'd7, 1'b1, 32'h4071D213);
        wait_drain("sequence");
    endtask

    task automatic test_branch_jal_hold;
        bit seen = 0;
        out_ready = 1'b0;
        send(4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b1, 32'hFE208EE3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL hold_valid_timeout: out_valid never rose");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++;
            if (out_valid !== 1'b1 || out_instr !== 32'hFE208EE3 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable: valid=%b instr=%08h in_ready=%b, expected 1 fe208ee3 0",
                         out_valid, out_instr, in_ready);
            end
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        send(4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h008000EF);
        send(4'd5, 3'b000, 1'b0, 5'd0, 5'd3, 5'd4, 32'd16, 1'b1, 32'h00419863);
        wait_drain("branch");
    endtask

`ifdef INSTR_ENCODER_CHECK_EN
    task automatic test_illegal;
        logic [7:0] addr_before;
        int         count_before;
        bit         leaked = 0;
        addr_before  = exp_addr;
        count_before = exp_count;
        send(4'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin @(negedge clock); if (out_valid !== 1'b0) leaked = 1; end
        total++;
        if (error !== 1'b1 || leaked) begin
            bad++;
            $display("FAIL err_imm12: error=%b leaked=%0d, expected error=1 leaked=0", error, leaked);
        end
        send(4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'h0);
        send(4'd9, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin @(negedge clock); if (out_valid !== 1'b0) leaked = 1; end
        total++;
        if (leaked || error !== 1'b1 || out_addr !== addr_before || count !== 16'(count_before)) begin
            bad++;
            $display("FAIL err_no_emit: leaked=%0d error=%b addr=%02h count=%0d, expected 0 1 %02h %0d",
                     leaked, error, out_addr, count, addr_before, count_before);
        end
        send(4'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7, 1'b1, 32'h00700093);
        wait_drain("after_error");
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got %b expected 1", error);
        end
    endtask
`else
    task automatic test_illegal;
        send(4'd9, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 32'h00000013);
        send(4'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h80000093);
        wait_drain("nocheck");
        total++;
        if (error !== 1'b0 || count !== 16'(exp_count)) begin
            bad++;
            $display("FAIL nop_kind: error=%b count=%0d, expected 0 %0d", error, count, exp_count);
        end
    endtask
`endif

    task automatic test_reset_in_output;
        bit seen = 0;
        out_ready = 1'b0;
        send(4'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid === 1'b1) begin seen = 1; break; end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rst_out_timeout: out_valid never rose");
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b0 || out_addr !== 8'h00 || count !== 16'h0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_in_output: valid=%b addr=%02h count=%0d in_ready=%b, expected 0 00 0 0",
                     out_valid, out_addr, count, in_ready);
        end
        exp_addr  = 8'h00;
        exp_count = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_wrap;
        logic [31:0] imm;
        out_ready = 1'b1;
        for (int i = 0; i < 65; i++) begin
            imm = 32'(i * 3);
            send(4'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, imm, 1'b1, {imm[11:0], 5'd0, 3'b000, 5'd1, 7'h13});
        end
        wait_drain("wrap");
        total++;
        if (count !== 16'd65 || out_addr !== 8'h04) begin
            bad++;
            $display("FAIL wrap_end: count=%0d addr=%02h, expected 65 04", count, out_addr);
        end
    endtask

    initial begin
        test_reset();
        test_addi_latency();
        test_sequence();
        test_branch_jal_hold();
        test_illegal();
        test_reset_in_output();
        test_wrap();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expected words never emitted", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
